// File: rtl/ecc_op_sequencer.sv
// Sequences up to 16 GF(2^m) engine ops from a host-loaded program; per op: FETCH+DECODE, engine time, GAP_CYCLES of NOP.
// No backpressure: each op waits for its own interrupt edge, bounded by TIMEOUT; abort forces ERR on the next cycle.
module ecc_op_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int TIMEOUT    = 1023,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [15:0] prog_data,
  input  logic        go,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [3:0]  pc,
  output logic [3:0]  b_command,
  output logic [2:0]  start_addr,
  output logic [2:0]  write_addr,
  output logic [1:0]  numbr_of_chunk,
  output logic        select_Ram_C_Or_D,
  output logic        select_Ram_A_Or_B,
  input  logic        interupt_sqr,
  input  logic        interupt_red,
  input  logic        interupt_swap,
  input  logic        interupt_mul,
  input  logic        interupt_Xor
);
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MUL  = 4'h1;
  localparam logic [3:0] OP_SQR  = 4'h2;
  localparam logic [3:0] OP_SWAP = 4'h3;
  localparam logic [3:0] OP_RED  = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_END  = 4'hF;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WAIT, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      pc_q, pc_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [3:0]      op_q, op_d;
  logic [2:0]      sa_q, sa_d;
  logic [2:0]      wa_q, wa_d;
  logic [1:0]      chunk_q, chunk_d;
  logic            cd_q, cd_d;
  logic            ab_q, ab_d;
  logic [4:0]      irq_q, irq_prev_q, irq_edge;
  logic            cmpl;
  logic            busy_int;
  logic [15:0]     mem [PROG_DEPTH];
  logic [15:0]     rd_q;
  logic            unused_rsvd;

  assign busy_int    = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                       (state_q == S_WAIT)  || (state_q == S_GAP);
  assign irq_edge    = irq_q & ~irq_prev_q;
  assign unused_rsvd = ^rd_q[1:0];

  // Program store is deliberately left out of reset so a loaded program survives rst_n.
  always_ff @(posedge clk) begin
    if (prog_we && !busy_int) mem[prog_addr] <= prog_data;
    rd_q <= mem[pc_q];
  end

  always_comb begin
    unique case (op_q)
      OP_MUL:  cmpl = irq_edge[3];
      OP_SQR:  cmpl = irq_edge[0];
      OP_RED:  cmpl = irq_edge[1];
      OP_SWAP: cmpl = irq_edge[2];
      OP_XOR:  cmpl = irq_edge[4];
      default: cmpl = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      err_code_q <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
      op_q       <= OP_NOP;
      sa_q       <= '0;
      wa_q       <= '0;
      chunk_q    <= '0;
      cd_q       <= 1'b0;
      ab_q       <= 1'b0;
      irq_q      <= '0;
      irq_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      err_code_q <= err_code_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      op_q       <= op_d;
      sa_q       <= sa_d;
      wa_q       <= wa_d;
      chunk_q    <= chunk_d;
      cd_q       <= cd_d;
      ab_q       <= ab_d;
      irq_q      <= {interupt_Xor, interupt_mul, interupt_swap, interupt_red, interupt_sqr};
      irq_prev_q <= irq_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    err_code_d = err_code_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    op_d       = op_q;
    sa_d       = sa_q;
    wa_d       = wa_q;
    chunk_d    = chunk_q;
    cd_d       = cd_q;
    ab_d       = ab_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (go) begin
          state_d    = S_FETCH;
          pc_d       = '0;
          err_code_d = 2'b00;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (rd_q[15:12])
          OP_END: state_d = S_DONE;
          OP_MUL, OP_SQR, OP_SWAP, OP_RED, OP_XOR: begin
            state_d = S_WAIT;
            op_d    = rd_q[15:12];
            sa_d    = rd_q[11:9];
            wa_d    = rd_q[8:6];
            chunk_d = rd_q[5:4];
            cd_d    = rd_q[3];
            ab_d    = rd_q[2];
            tmo_d   = '0;
          end
          default: begin
            state_d    = S_ERR;
            err_code_d = 2'b10;
          end
        endcase
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // A completion landing on the timeout cycle still counts as success.
        if (cmpl) begin
          state_d = S_GAP;
          gap_d   = '0;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d    = S_ERR;
          err_code_d = 2'b01;
        end
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          if (pc_q == 4'(PROG_DEPTH - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            pc_d    = pc_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (busy_int && abort) begin
      state_d    = S_ERR;
      err_code_d = 2'b11;
    end
  end

  // b_command is decoded from state so it only leaves NOP while in WAIT.
  always_comb begin
    busy              = busy_int;
    done              = (state_q == S_DONE);
    error             = (state_q == S_ERR);
    err_code          = err_code_q;
    pc                = pc_q;
    b_command         = (state_q == S_WAIT) ? op_q : OP_NOP;
    start_addr        = sa_q;
    write_addr        = wa_q;
    numbr_of_chunk    = chunk_q;
    select_Ram_C_Or_D = cd_q;
    select_Ram_A_Or_B = ab_q;
  end

endmodule

// File: tb/tb_ecc_op_sequencer.sv
// Directed bench for ecc_op_sequencer: program runs, interrupt matching, timeout,
// illegal opcode, abort/rerun, full 16-entry program and async reset.
module tb_ecc_op_sequencer;
  localparam int TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic        go;
  logic        abort;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [3:0]  pc;
  logic [3:0]  b_command;
  logic [2:0]  start_addr, write_addr;
  logic [1:0]  numbr_of_chunk;
  logic        select_Ram_C_Or_D, select_Ram_A_Or_B;
  logic [4:0]  irq;  // {xor, mul, swap, red, sqr}

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ecc_op_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .prog_we           (prog_we),
    .prog_addr         (prog_addr),
    .prog_data         (prog_data),
    .go                (go),
    .abort             (abort),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .err_code          (err_code),
    .pc                (pc),
    .b_command         (b_command),
    .start_addr        (start_addr),
    .write_addr        (write_addr),
    .numbr_of_chunk    (numbr_of_chunk),
    .select_Ram_C_Or_D (select_Ram_C_Or_D),
    .select_Ram_A_Or_B (select_Ram_A_Or_B),
    .interupt_sqr      (irq[0]),
    .interupt_red      (irq[1]),
    .interupt_swap     (irq[2]),
    .interupt_mul      (irq[3]),
    .interupt_Xor      (irq[4])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] outs();
    return {busy, done, error, err_code, pc, b_command, start_addr, write_addr,
            numbr_of_chunk, select_Ram_C_Or_D, select_Ram_A_Or_B};
  endfunction

  function automatic logic [9:0] fields();
    return {start_addr, write_addr, numbr_of_chunk, select_Ram_C_Or_D, select_Ram_A_Or_B};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  task automatic pulse_irq(input int b);
    irq[b] = 1'b1;
    step();
    step();
    irq[b] = 1'b0;
  endtask

  task automatic wait_cmd(input logic [3:0] exp, input string tag);
    for (int i = 0; i < 20; i++) begin
      if (b_command == exp) break;
      step();
    end
    chk(tag, b_command, exp);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      step();
    end
    chk(tag, done, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic issued;
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    go = 1'b0; abort = 1'b0; irq = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 0);
    rst_n = 1'b1;
    step();

    // Program 1: MUL sa=2, SQR sa=1, END
    load(4'd0, 16'h1400);
    load(4'd1, 16'h2200);
    load(4'd2, 16'hF000);
    pulse_go();
    chk("t1_busy", busy, 1);
    wait_cmd(4'h1, "t1_mul_issue");
    chk("t1_mul_sa", start_addr, 2);
    repeat (9) step();
    chk("t1_mul_hold", b_command, 1);
    pulse_irq(3);
    chk("t1_gap_nop", b_command, 0);
    repeat (3) step();
    chk("t1_gap_to_decode_nop", b_command, 0);
    step();
    chk("t1_sqr_issue", b_command, 2);
    chk("t1_sqr_sa", start_addr, 1);
    chk("t1_sqr_pc", pc, 1);
    repeat (4) step();
    pulse_irq(0);
    chk("t1_gap2_nop", b_command, 0);
    repeat (4) step();
    chk("t1_done", done, 1);
    chk("t1_busy_at_done", busy, 0);
    step();
    chk("t1_done_once", done, 0);
    chk("t1_busy_after", busy, 0);
    chk("t1_error", error, 0);

    // SWAP with all fields populated; mul edge must be ignored
    load(4'd0, 16'h3768);
    load(4'd1, 16'hF000);
    pulse_go();
    wait_cmd(4'h3, "t2_swap_issue");
    chk("t2_fields", fields(), 10'b011_101_10_1_0);
    pulse_irq(3);
    step();
    chk("t2_mul_ignored", b_command, 3);
    chk("t2_fields_hold", fields(), 10'b011_101_10_1_0);
    pulse_irq(2);
    chk("t2_swap_done_nop", b_command, 0);
    chk("t2_fields_in_gap", fields(), 10'b011_101_10_1_0);
    wait_done("t2_done");

    // RED with no interrupt: timeout exactly TIMEOUT cycles after WAIT entry
    load(4'd0, 16'h4000);
    pulse_go();
    wait_cmd(4'h4, "t3_red_issue");
    repeat (TIMEOUT - 1) step();
    chk("t3_pre_timeout_err", error, 0);
    chk("t3_pre_timeout_cmd", b_command, 4);
    step();
    chk("t3_error", error, 1);
    chk("t3_err_code", err_code, 2'b01);
    chk("t3_pc", pc, 0);
    chk("t3_cmd", b_command, 0);
    chk("t3_busy", busy, 0);

    // Illegal opcode in entry 1
    load(4'd0, 16'h1000);
    load(4'd1, 16'h7000);
    pulse_go();
    chk("t4_err_cleared", error, 0);
    chk("t4_code_cleared", err_code, 0);
    wait_cmd(4'h1, "t4_mul_issue");
    pulse_irq(3);
    issued = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (error) break;
      if (b_command != 4'h0) issued = 1'b1;
      step();
    end
    chk("t4_error", error, 1);
    chk("t4_err_code", err_code, 2'b10);
    chk("t4_pc", pc, 1);
    chk("t4_no_issue", issued, 0);

    // Abort during XOR, write and go while busy ignored, rerun from pc 0
    load(4'd0, 16'h5000);
    load(4'd1, 16'hF000);
    pulse_go();
    wait_cmd(4'h5, "t5_xor_issue");
    load(4'd0, 16'h4000);
    pulse_go();
    chk("t5_go_busy_cmd", b_command, 5);
    chk("t5_go_busy_pc", pc, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_abort_cmd", b_command, 0);
    chk("t5_abort_code", err_code, 2'b11);
    chk("t5_abort_err", error, 1);
    pulse_go();
    chk("t5_rerun_pc", pc, 0);
    wait_cmd(4'h5, "t5_rerun_mem_kept");
    pulse_irq(4);
    wait_done("t5_done");

    // 16 XOR entries, no END
    for (int i = 0; i < 16; i++) load(4'(i), 16'h5000);
    pulse_go();
    for (int i = 0; i < 16; i++) begin
      wait_cmd(4'h5, "t6_xor_issue");
      chk("t6_pc", pc, i);
      pulse_irq(4);
    end
    wait_done("t6_done");
    chk("t6_pc_last", pc, 15);

    // Async reset mid-WAIT
    pulse_go();
    wait_cmd(4'h5, "t7_xor_issue");
    rst_n = 1'b0;
    #1;
    chk("t7_async_reset", outs(), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("t7_after_reset", outs(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
